// File: rtl/split12_gen_pkg.sv
// +----------------------------------------------------------------------+
// | split12_gen_pkg : shared widths, FSM states and constants for the    |
// |                   split_12 witness generator.                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package split12_gen_pkg;

    localparam int V12_W  = 14;
    localparam int V144_W = 16;
    localparam int CAND_W = 30;

    localparam logic [V144_W-1:0] C85_MASK = 16'h8622;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        HOLD   = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/split12_pred.sv
// +----------------------------------------------------------------------+
// | split12_pred : combinational split_12 predicate (c31 & c40 & c52 &   |
// |                c85) over one (var_12, var_144) candidate.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module split12_pred
    import split12_gen_pkg::*;
(
    input  logic [V12_W-1:0]  var_12_i,
    input  logic [V144_W-1:0] var_144_i,
    output logic              hit_o
);

    logic c31;
    logic c40;
    logic c52;
    logic c85;

    assign c31 = (var_12_i == '0);
    assign c40 = (var_144_i == '0);
    // Both sides widened to 16 bits so the comparison matches the checker exactly.
    assign c52 = ({{(V144_W-1){1'b0}}, !var_144_i} != {{(V144_W-V12_W){1'b0}}, var_12_i});
    assign c85 = |((var_144_i << 6) | C85_MASK);

    assign hit_o = c31 & c52 & c40 & c85;

endmodule

`default_nettype wire

// File: rtl/split_12_witness_gen.sv
// +----------------------------------------------------------------------+
// | split_12_witness_gen : walks candidates from a seed, one per clock,  |
// |   and emits the first split_12 witness or pulses fail. Optional      |
// |   macro SPLIT12_GEN_STATS_EN adds the tries_o evaluation counter.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module split_12_witness_gen
    import split12_gen_pkg::*;
#(
    parameter int MAX_ITER = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CAND_W-1:0] seed,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [V12_W-1:0]  var_12_o,
    output logic [V144_W-1:0] var_144_o,
`ifdef SPLIT12_GEN_STATS_EN
    output logic [31:0]       tries_o,
`endif
    output logic              fail
);

    localparam int ITER_W = $clog2(MAX_ITER + 1);
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(MAX_ITER - 1);

    state_t              state_q;
    logic [CAND_W-1:0]   cand_q;
    logic [CAND_W-1:0]   cand_d;
    logic [ITER_W-1:0]   iter_q;
    logic                busy_q;
    logic                valid_q;
    logic                fail_q;
    logic [V12_W-1:0]    var_12_q;
    logic [V144_W-1:0]   var_144_q;
    logic                cand_hit;
`ifdef SPLIT12_GEN_STATS_EN
    logic [31:0]         tries_q;
`endif

    // Natural 30-bit wrap takes the last candidate back to zero.
    assign cand_d = cand_q + CAND_W'(1);

    split12_pred u_pred (
        .var_12_i  (cand_q[V12_W-1:0]),
        .var_144_i (cand_q[CAND_W-1:V12_W]),
        .hit_o     (cand_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cand_q    <= '0;
            iter_q    <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            fail_q    <= 1'b0;
            var_12_q  <= '0;
            var_144_q <= '0;
`ifdef SPLIT12_GEN_STATS_EN
            tries_q   <= '0;
`endif
        end else begin
            fail_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cand_q  <= seed;
                        iter_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SEARCH;
`ifdef SPLIT12_GEN_STATS_EN
                        tries_q <= '0;
`endif
                    end
                end
                SEARCH: begin
`ifdef SPLIT12_GEN_STATS_EN
                    tries_q <= tries_q + 32'd1;
`endif
                    // A hit on the final budgeted candidate still wins over failure.
                    if (cand_hit) begin
                        var_12_q  <= cand_q[V12_W-1:0];
                        var_144_q <= cand_q[CAND_W-1:V12_W];
                        valid_q   <= 1'b1;
                        state_q   <= HOLD;
                    end else if (iter_q == LAST_ITER) begin
                        fail_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cand_q <= cand_d;
                        iter_q <= iter_q + ITER_W'(1);
                    end
                end
                HOLD: begin
                    if (valid_q && out_ready) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign fail      = fail_q;
    assign var_12_o  = var_12_q;
    assign var_144_o = var_144_q;
`ifdef SPLIT12_GEN_STATS_EN
    assign tries_o   = tries_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_split_12_witness_gen.sv
// +----------------------------------------------------------------------+
// | tb_split_12_witness_gen : scoreboard bench for split_12_witness_gen. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_split_12_witness_gen;

    localparam int MAX_ITER = 16;

    typedef struct packed {
        logic        is_fail;
        logic [31:0] lat;
        logic [13:0] v12;
        logic [15:0] v144;
        logic [31:0] tries;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [29:0] seed;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] var_12_o;
    logic [15:0] var_144_o;
    logic        fail;
    logic        ref_hit;
`ifdef SPLIT12_GEN_STATS_EN
    logic [31:0] tries_o;
`endif

    int   checks;
    int   errors;
    exp_t sb[$];

    split_12_witness_gen #(.MAX_ITER(MAX_ITER)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .seed      (seed),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .var_12_o  (var_12_o),
        .var_144_o (var_144_o),
`ifdef SPLIT12_GEN_STATS_EN
        .tries_o   (tries_o),
`endif
        .fail      (fail)
    );

    // Emitted witness driven back through the predicate (the checker's x).
    split12_pred u_ref (
        .var_12_i  (var_12_o),
        .var_144_i (var_144_o),
        .hit_o     (ref_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit model_hit(input logic [13:0] a, input logic [15:0] b);
        logic [15:0] nb;
        nb = {15'b0, (b == 16'd0)};
        return (a == 14'd0) && (b == 16'd0) && (nb != {2'b00, a})
            && (((b << 6) | 16'h8622) != 16'd0);
    endfunction

    function automatic exp_t model(input logic [29:0] s);
        exp_t        e;
        logic [29:0] c;
        e = '0;
        e.is_fail = 1'b1;
        e.lat     = 32'(MAX_ITER);
        e.tries   = 32'(MAX_ITER);
        for (int i = 0; i < MAX_ITER; i++) begin
            c = s + 30'(i);
            if (model_hit(c[13:0], c[29:14])) begin
                e.is_fail = 1'b0;
                e.lat     = 32'(i + 1);
                e.tries   = 32'(i + 1);
                e.v12     = c[13:0];
                e.v144    = c[29:14];
                return e;
            end
        end
        return e;
    endfunction

    // Drives one search (inputs changed on negedge) and scores its outcome.
    task automatic run(input logic [29:0] s, input int hold);
        exp_t e;
        int   j;
        logic seen;
        start     = 1'b1;
        seed      = s;
        out_ready = (hold == 0);
        sb.push_back(model(s));
        @(negedge clk);
        start = 1'b0;
        check("busy_search", {31'b0, busy}, 32'd1);
        j    = 0;
        seen = 1'b0;
        while (!seen && j < MAX_ITER + 4) begin
            @(negedge clk);
            j++;
            seen = out_valid | fail;
        end
        check("event_seen", {31'b0, seen}, 32'd1);
        e = sb.pop_front();
        if (!seen) return;
        check("fail_flag", {31'b0, fail}, {31'b0, e.is_fail});
        check("valid_flag", {31'b0, out_valid}, {31'b0, !e.is_fail});
        check("latency", 32'(j), e.lat);
`ifdef SPLIT12_GEN_STATS_EN
        check("tries", tries_o, e.tries);
`endif
        if (!e.is_fail) begin
            check("var_12", {18'b0, var_12_o}, {18'b0, e.v12});
            check("var_144", {16'b0, var_144_o}, {16'b0, e.v144});
            check("witness_x", {31'b0, ref_hit}, 32'd1);
            for (int h = 0; h < hold; h++) begin
                start = (h == 3);
                seed  = 30'h0000_1234;
                @(negedge clk);
                start = 1'b0;
                check("hold_valid", {31'b0, out_valid}, 32'd1);
                check("hold_busy", {31'b0, busy}, 32'd1);
                check("hold_v12", {18'b0, var_12_o}, {18'b0, e.v12});
                check("hold_v144", {16'b0, var_144_o}, {16'b0, e.v144});
            end
            out_ready = 1'b1;
            @(negedge clk);
            check("xfer_valid", {31'b0, out_valid}, 32'd0);
            check("xfer_busy", {31'b0, busy}, 32'd0);
            if (hold > 0) begin
                @(negedge clk);
                check("no_queued_start", {31'b0, busy}, 32'd0);
            end
        end else begin
            @(negedge clk);
            check("fail_pulse_len", {31'b0, fail}, 32'd0);
            check("fail_busy", {31'b0, busy}, 32'd0);
            check("fail_valid", {31'b0, out_valid}, 32'd0);
        end
    endtask

    initial begin
        logic quiet;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        seed      = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_fail", {31'b0, fail}, 32'd0);
        check("rst_v12", {18'b0, var_12_o}, 32'd0);
        check("rst_v144", {16'b0, var_144_o}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run(30'h0000_0000, 0);
        run(30'h3FFF_FFFD, 0);
        run(30'h0000_4000, 0);
        run(30'h0000_0000, 10);
        run(30'h3FFF_FFF1, 0);
        run(30'h3FFF_FFF0, 0);

        // Reset in the middle of a search aborts it silently.
        start     = 1'b1;
        seed      = 30'h3FFF_FFF0;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_fail", {31'b0, fail}, 32'd0);
`ifdef SPLIT12_GEN_STATS_EN
        check("midrst_tries", tries_o, 32'd0);
`endif
        quiet = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (out_valid || fail || busy) quiet = 1'b0;
        end
        check("midrst_quiet", {31'b0, quiet}, 32'd1);

        run(30'h0000_0000, 0);
        for (int r = 0; r < 4; r++) begin
            run(30'h3FFF_FFE0 | 30'($urandom_range(0, 31)), r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
